traffic_ctrl: RTL

- Control-path counterpart of the traffic-light datapath. Issues the one-hot `cmd_flags` and the `cnt_rst` pulse that the datapath consumes, and advances on the datapath's `int_flags` completion flags.
- Sequence: INIT → G → Y → R → G → … with pause, per-state watchdog, fault (blinking yellow) handling and a completed-cycle counter.
- Sits beside the datapath in the light top level. The shared `CMD_FLAG_W`/`INT_FLAG_W`/`CMD_*`/`INT_*` defines are used as-is.

---
 rtl/traffic_ctrl_if.sv | 64 ++++++
 rtl/traffic_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl_if
// Purpose  : Bundles the control/flag signals exchanged between the traffic
//            light control path (traffic_ctrl) and its environment.
// Signals  : en, clr_fault, int_flags        -> driven by master
//            cmd_flags, cnt_rst, fault,
//            state_o, cycle_cnt              -> driven by slave (controller)
// Revision : 1.0 - initial release
// ============================================================================

`ifndef CMD_FLAG_W
`define CMD_FLAG_W 4
`endif
`ifndef INT_FLAG_W
`define INT_FLAG_W 4
`endif
`ifndef CMD_INIT
`define CMD_INIT 0
`endif
`ifndef CMD_G
`define CMD_G 1
`endif
`ifndef CMD_Y
`define CMD_Y 2
`endif
`ifndef CMD_R
`define CMD_R 3
`endif
`ifndef INT_INIT
`define INT_INIT 0
`endif
`ifndef INT_G
`define INT_G 1
`endif
`ifndef INT_Y
`define INT_Y 2
`endif
`ifndef INT_R
`define INT_R 3
`endif

interface traffic_ctrl_if;
  logic                   en;
  logic                   clr_fault;
  logic [`INT_FLAG_W-1:0] int_flags;
  logic [`CMD_FLAG_W-1:0] cmd_flags;
  logic                   cnt_rst;
  logic                   fault;
  logic [2:0]             state_o;
  logic [15:0]            cycle_cnt;

  modport master (
    output en, clr_fault, int_flags,
    input  cmd_flags, cnt_rst, fault, state_o, cycle_cnt
  );

  modport slave (
    input  en, clr_fault, int_flags,
    output cmd_flags, cnt_rst, fault, state_o, cycle_cnt
  );
endinterface

`default_nettype wire

// File: rtl/traffic_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_ctrl
// Purpose  : Control path of the traffic light. Sequences INIT -> G -> Y -> R
//            -> G ..., issuing one-hot commands and a counter-clear pulse to
//            the datapath, with pause, per-state watchdog, blinking-yellow
//            fault state and a completed-cycle counter.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-low reset
//            bus   - traffic_ctrl_if.slave (en, clr_fault, int_flags in;
//                    cmd_flags, cnt_rst, fault, state_o, cycle_cnt out)
// Revision : 1.0 - initial release
// ============================================================================

module traffic_ctrl #(
  parameter int TIMEOUT = 2048,
  parameter int TO_W    = 12,
  parameter int BLINK   = 64
) (
  input  logic          clk,
  input  logic          reset,
  traffic_ctrl_if.slave bus
);

  localparam int c_bl_w = (BLINK > 1) ? $clog2(BLINK) : 1;

  typedef logic [`CMD_FLAG_W-1:0] cmd_t;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_INIT  = 3'd1,
    S_G     = 3'd2,
    S_Y     = 3'd3,
    S_R     = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [TO_W-1:0]   c_wd_last    = TO_W'(TIMEOUT - 1);
  localparam logic [c_bl_w-1:0] c_blink_last = c_bl_w'(BLINK - 1);
  localparam cmd_t              c_cmd_y      = cmd_t'(1) << `CMD_Y;

  state_t              r_state;
  logic [TO_W-1:0]     r_wd;
  logic [c_bl_w-1:0]   r_blink;
  cmd_t                r_cmd;
  logic                r_cnt_rst;
  logic                r_fault;
  logic [15:0]         r_cycle_cnt;

  logic   w_run;
  logic   w_flag;
  logic   w_qual;
  logic   w_timeout;
  state_t w_succ;

  // One-hot command for a run state; all-zero while paused.
  function automatic cmd_t f_cmd(input state_t s, input logic run_en);
    cmd_t v;
    v = '0;
    if (run_en) begin
      case (s)
        S_INIT:  v[`CMD_INIT] = 1'b1;
        S_G:     v[`CMD_G]    = 1'b1;
        S_Y:     v[`CMD_Y]    = 1'b1;
        S_R:     v[`CMD_R]    = 1'b1;
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // Only the completion flag of the current state matters. It is ignored for
  // the first two cycles because the datapath still derives it from the
  // pre-clear count while cnt_rst is being applied.
  always_comb begin
    w_run  = 1'b1;
    w_flag = 1'b0;
    w_succ = S_BOOT;
    case (r_state)
      S_INIT: begin w_flag = bus.int_flags[`INT_INIT]; w_succ = S_G; end
      S_G:    begin w_flag = bus.int_flags[`INT_G];    w_succ = S_Y; end
      S_Y:    begin w_flag = bus.int_flags[`INT_Y];    w_succ = S_R; end
      S_R:    begin w_flag = bus.int_flags[`INT_R];    w_succ = S_G; end
      default: w_run = 1'b0;
    endcase
    w_qual    = w_run && bus.en && w_flag && (r_wd >= TO_W'(2));
    w_timeout = w_run && bus.en && (r_wd == c_wd_last);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_BOOT;
      r_wd        <= '0;
      r_blink     <= '0;
      r_cmd       <= '0;
      r_cnt_rst   <= 1'b0;
      r_fault     <= 1'b0;
      r_cycle_cnt <= '0;
    end else begin
      r_cnt_rst <= 1'b0;
      case (r_state)
        S_BOOT: begin
          r_state   <= S_INIT;
          r_cnt_rst <= 1'b1;
          r_wd      <= '0;
          r_cmd     <= f_cmd(S_INIT, bus.en);
        end
        S_INIT, S_G, S_Y, S_R: begin
          // Completion takes priority over the watchdog on the same edge.
          if (w_qual) begin
            r_state   <= w_succ;
            r_cnt_rst <= 1'b1;
            r_wd      <= '0;
            r_cmd     <= f_cmd(w_succ, 1'b1);
            if (r_state == S_R) begin
              r_cycle_cnt <= r_cycle_cnt + 16'd1;
            end
          end else if (w_timeout) begin
            r_state   <= S_FAULT;
            r_cnt_rst <= 1'b1;
            r_wd      <= '0;
            r_fault   <= 1'b1;
            r_blink   <= '0;
            r_cmd     <= c_cmd_y;
          end else begin
            if (bus.en) begin
              r_wd <= r_wd + TO_W'(1);
            end
            r_cmd <= f_cmd(r_state, bus.en);
          end
        end
        S_FAULT: begin
          if (bus.clr_fault) begin
            r_state   <= S_INIT;
            r_cnt_rst <= 1'b1;
            r_fault   <= 1'b0;
            r_blink   <= '0;
            r_wd      <= '0;
            r_cmd     <= f_cmd(S_INIT, bus.en);
          end else if (r_blink == c_blink_last) begin
            // Yellow is the only bit ever set here, so XOR toggles it alone.
            r_blink <= '0;
            r_cmd   <= r_cmd ^ c_cmd_y;
          end else begin
            r_blink <= r_blink + c_bl_w'(1);
          end
        end
        default: begin
          r_state   <= S_BOOT;
          r_cnt_rst <= 1'b1;
          r_fault   <= 1'b0;
          r_wd      <= '0;
          r_blink   <= '0;
          r_cmd     <= '0;
        end
      endcase
    end
  end

  assign bus.cmd_flags = r_cmd;
  assign bus.cnt_rst   = r_cnt_rst;
  assign bus.fault     = r_fault;
  assign bus.state_o   = r_state;
  assign bus.cycle_cnt = r_cycle_cnt;

endmodule

`default_nettype wire
